// File: rtl/regfile_mp.sv
// regfile_mp: 1W/2R register file with a sequential clear sweep.
// Optional feature: define REGFILE_BYPASS_EN for write-first reads.
module regfile_mp #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 0,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              busy,
   output logic              wr_drop
);

   typedef enum logic {CLEAR, READY} state_t;

   localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST  = AW'(DEPTH-1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, state_nxt;
   logic [AW-1:0]     ptr, ptr_nxt;
   logic              sweep_we, wr_ok, drop_nxt;
   logic              ok_w, ok_a, ok_b, rd_zero;
   logic [DATA_W-1:0] rd_a_nxt, rd_b_nxt;

   // An address is usable if it exists and is not the hard-wired zero entry.
   function automatic logic usable(input logic [AW-1:0] a);
      return ({1'b0, a} < LIMIT) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign ok_w    = usable(waddr);
   assign ok_a    = usable(raddr_a);
   assign ok_b    = usable(raddr_b);
   assign rd_zero = (state == CLEAR) || clr;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sweep_we  = 1'b0;
      wr_ok     = 1'b0;
      if (clr) begin
         state_nxt = CLEAR;
         ptr_nxt   = '0;
      end else if (state == CLEAR) begin
         sweep_we = 1'b1;
         ptr_nxt  = ptr + AW'(1);
         if (ptr == LAST)
            state_nxt = READY;
      end else begin
         wr_ok = we && ok_w;
      end
      drop_nxt = we && !wr_ok;
   end

   always_comb begin
      rd_a_nxt = '0;
      rd_b_nxt = '0;
      if (!rd_zero && ok_a)
         rd_a_nxt = mem[raddr_a];
      if (!rd_zero && ok_b)
         rd_b_nxt = mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (!rd_zero && ok_a && wr_ok && (raddr_a == waddr))
         rd_a_nxt = wdata;
      if (!rd_zero && ok_b && wr_ok && (raddr_b == waddr))
         rd_b_nxt = wdata;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         ptr     <= '0;
         rdata_a <= '0;
         rdata_b <= '0;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         rdata_a <= rd_a_nxt;
         rdata_b <= rd_b_nxt;
         wr_drop <= drop_nxt;
      end
   end

   // Storage has no reset of its own; the sweep is what zeroes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (sweep_we)
            mem[ptr] <= '0;
         else if (wr_ok)
            mem[waddr] <= wdata;
      end
   end

   assign busy = (state == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of sweep, R/W, hazards, clr and zero reg.
// Expected values are hand-computed constants.
module tb_regfile_mp;

   logic       clk = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic       rst = 1'b1, clr = 1'b0, we = 1'b0;
   logic [2:0] waddr = '0, raddr_a = '0, raddr_b = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata_a, rdata_b;
   logic       busy, wr_drop;

   logic       rst1 = 1'b1, clr1 = 1'b0, we1 = 1'b0;
   logic [2:0] waddr1 = '0, raddr_a1 = '0, raddr_b1 = '0;
   logic [7:0] wdata1 = '0;
   logic [7:0] rdata_a1, rdata_b1;
   logic       busy1, wr_drop1;

   logic [7:0] hz_exp;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(8), .DEPTH(8), .ZERO_REG(0)) u0 (
      .clk(clk), .rst(rst), .clr(clr), .we(we),
      .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .busy(busy), .wr_drop(wr_drop)
   );

   regfile_mp #(.DATA_W(8), .DEPTH(6), .ZERO_REG(1)) u1 (
      .clk(clk), .rst(rst1), .clr(clr1), .we(we1),
      .waddr(waddr1), .wdata(wdata1),
      .raddr_a(raddr_a1), .raddr_b(raddr_b1),
      .rdata_a(rdata_a1), .rdata_b(rdata_b1),
      .busy(busy1), .wr_drop(wr_drop1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef REGFILE_BYPASS_EN
      hz_exp = 8'h22;
`else
      hz_exp = 8'h11;
`endif
      // reset held two cycles
      tick;
      tick;
      chk("rst_busy", busy, 1);
      chk("rst_rda", rdata_a, 0);
      chk("rst_rdb", rdata_b, 0);
      chk("rst_drop", wr_drop, 0);

      // sweep with a write attempted during busy
      rst = 1'b0;
      we = 1'b1; waddr = 3'd0; wdata = 8'hA5;
      raddr_a = 3'd0; raddr_b = 3'd1;
      tick;
      chk("sweep_drop", wr_drop, 1);
      chk("sweep_busy1", busy, 1);
      we = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         tick;
         chk("sweep_busy", busy, (k < 8) ? 1 : 0);
         chk("sweep_rda", rdata_a, 0);
         chk("sweep_rdb", rdata_b, 0);
         if (k == 2)
            chk("sweep_drop_end", wr_drop, 0);
      end

      // basic write/read
      we = 1'b1; waddr = 3'd1; wdata = 8'hA5; raddr_a = 3'd0;
      tick;
      chk("e0_unchanged", rdata_a, 0);
      chk("w1_nodrop", wr_drop, 0);
      waddr = 3'd2; wdata = 8'h5A;
      tick;
      we = 1'b0; raddr_a = 3'd1; raddr_b = 3'd2;
      tick;
      chk("rd_a1", rdata_a, 8'hA5);
      chk("rd_b2", rdata_b, 8'h5A);

      // same-cycle write/read hazard
      we = 1'b1; waddr = 3'd3; wdata = 8'h11;
      tick;
      wdata = 8'h22; raddr_a = 3'd3; raddr_b = 3'd3;
      tick;
      chk("hazard_a", rdata_a, hz_exp);
      chk("hazard_b", rdata_b, hz_exp);
      we = 1'b0;
      tick;
      chk("hazard_after_a", rdata_a, 8'h22);
      chk("hazard_after_b", rdata_b, 8'h22);

      // clr wins over write
      clr = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'hFF;
      tick;
      chk("clr_drop", wr_drop, 1);
      chk("clr_busy0", busy, 1);
      chk("clr_rda", rdata_a, 0);
      clr = 1'b0; we = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         chk("clr_busy", busy, (k < 8) ? 1 : 0);
      end
      for (int i = 0; i < 8; i++) begin
         raddr_a = 3'(i); raddr_b = 3'(7 - i);
         tick;
         chk("clr_zero_a", rdata_a, 0);
         chk("clr_zero_b", rdata_b, 0);
      end

      // write after clear, then reset mid-sweep
      we = 1'b1; waddr = 3'd5; wdata = 8'hC3;
      tick;
      we = 1'b0; raddr_a = 3'd5;
      tick;
      chk("post_clr_wr", rdata_a, 8'hC3);
      clr = 1'b1;
      tick;
      clr = 1'b0;
      for (int k = 0; k < 4; k++)
         tick;
      chk("mid_busy", busy, 1);
      rst = 1'b1; we = 1'b1; waddr = 3'd6; wdata = 8'h99;
      tick;
      chk("mid_rst_nodrop", wr_drop, 0);
      chk("mid_rst_busy", busy, 1);
      rst = 1'b0; we = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         chk("mid_busy_after", busy, (k < 8) ? 1 : 0);
      end
      raddr_a = 3'd5; raddr_b = 3'd6;
      tick;
      chk("mid_e5_zero", rdata_a, 0);
      chk("mid_e6_zero", rdata_b, 0);

      // ZERO_REG=1, DEPTH=6 instance
      rst1 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick;
         chk("z_busy", busy1, (k < 6) ? 1 : 0);
      end
      we1 = 1'b1; waddr1 = 3'd0; wdata1 = 8'h77; raddr_a1 = 3'd0;
      tick;
      chk("z_w0_drop", wr_drop1, 1);
      waddr1 = 3'd1; wdata1 = 8'h66;
      tick;
      chk("z_w1_ok", wr_drop1, 0);
      chk("z_rd0_bypass", rdata_a1, 0);
      waddr1 = 3'd6; wdata1 = 8'h55;
      tick;
      chk("z_w6_drop", wr_drop1, 1);
      we1 = 1'b0; raddr_a1 = 3'd0; raddr_b1 = 3'd1;
      tick;
      chk("z_rd0", rdata_a1, 0);
      chk("z_rd1", rdata_b1, 8'h66);
      chk("z_drop_clr", wr_drop1, 0);
      raddr_a1 = 3'd7; raddr_b1 = 3'd6;
      tick;
      chk("z_rd7", rdata_a1, 0);
      chk("z_rd6", rdata_b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
